btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-input cycles required before the output changes (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 20: width of each per-channel debounce counter.
REQ-004 Parameter LONG_CYCLES, default 200000000: held cycles for a long press (2 s at 100 MHz); used only with BTN_DEBOUNCE_LONGPRESS_EN.
REQ-005 Port clk_100mhz, input, 1: the single clock; all flops sample on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port btn_i, input, WIDTH: raw asynchronous button pins, active-high.
REQ-008 Port btn_o, output, WIDTH: debounced level per channel.
REQ-009 Port rise_o, output, WIDTH: one-cycle pulse in the first cycle btn_o[n] is 1 after being 0.
REQ-010 Port fall_o, output, WIDTH: one-cycle pulse in the first cycle btn_o[n] is 0 after being 1.
REQ-011 Port long_o, output, WIDTH: one-cycle long-press pulse per channel.

Function
REQ-012 Each btn_i[n] shall pass through a 2-flop synchronizer; only the second flop output (sync[n]) feeds further logic.
REQ-013 Per channel, the FSM shall have two states, STABLE (sync == btn_o) and PENDING (sync != btn_o).
REQ-014 In STABLE the counter shall be held at 0.
REQ-015 In PENDING the counter shall increment by 1 per cycle.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, on the next edge btn_o[n] shall take sync[n], the counter shall clear and the FSM shall return to STABLE.
REQ-017 If sync returns to btn_o before that point (bounce), the counter shall clear on the next edge with btn_o unchanged.
REQ-018 The counter shall never wrap: because every level mismatch clears it, DEBOUNCE_CYCLES-1 is its maximum value.
REQ-019 Latency: a clean edge on btn_i shall reach btn_o exactly 2 + DEBOUNCE_CYCLES cycles later.
REQ-020 rise_o and fall_o shall be registered and asserted in the same cycle btn_o changes, for exactly one cycle; the two are never asserted together on one channel.
REQ-021 Channels shall be fully independent; simultaneous transitions on several channels each behave per REQ-016.

Reset
REQ-022 While reset is high: synchronizer flops, btn_o, rise_o, fall_o, long_o and all counters shall be 0, and every FSM shall be in STABLE.
REQ-023 Reset asserted mid-PENDING shall discard the pending count.
REQ-024 After reset release with btn_i held high, btn_o shall rise 2 + DEBOUNCE_CYCLES cycles later, together with a rise_o pulse.

Configuration
REQ-025 Macro BTN_DEBOUNCE_LONGPRESS_EN defined: each channel shall have a hold counter.
  - The hold counter is cleared while btn_o[n] = 0.
  - It increments while btn_o[n] = 1 and saturates at LONG_CYCLES.
  - long_o[n] pulses for one cycle in the cycle the counter first reaches LONG_CYCLES.
  - At most one pulse per press; a new pulse requires a release (btn_o = 0) first.
REQ-026 Macro undefined: long_o shall be constant 0 and no hold-counter logic shall be synthesized.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-027 Clean press: btn_i[0] 0->1 at cycle 0 and held -> btn_o[0]=1 and rise_o[0]=1 at cycle 6 only; btn_o[1] stays 0.
REQ-028 Bounce: btn_i[0] toggles 1,0,1,0 every 2 cycles, then holds 1 -> btn_o[0] rises exactly 6 cycles after the final 0->1 edge, with a single rise_o pulse.
REQ-029 Release: from btn_o[0]=1, btn_i[0] 1->0 at cycle 0 -> btn_o[0]=0 and fall_o[0]=1 at cycle 6 only.
REQ-030 Reset mid-operation: btn_i[1]=1, reset pulsed at cycle 3 (PENDING) -> all outputs 0; btn_o[1] rises 6 cycles after reset release.
REQ-031 Long press (macro defined): btn_o[0]=1 held for 40 cycles -> exactly one long_o[0] pulse, 16 cycles after btn_o[0] rose; macro undefined -> long_o stays 0.
REQ-032 Simultaneous: both btn_i bits 0->1 at cycle 0 -> both btn_o bits and both rise_o bits assert at cycle 6.

Source files
------------

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, per-channel STABLE/PENDING counter FSM,
// registered edge pulses. Optional long-press detector enabled by BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned LONG_CYCLES     = 200000000
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] long_o
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        btn_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        btn_q   <= btn_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      cnt_d = '0;
      btn_d = btn_q;
      unique case (state_q)
        STABLE: cnt_d = '0;
        PENDING: begin
          if (cnt_q == CNT_MAX) begin
            btn_d = sync2_q[n];
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
      // sync1 is next cycle's sync2, so the registered state always equals (sync != btn_o)
      state_d = (sync1_q[n] != btn_d) ? PENDING : STABLE;
      rise_d  = btn_d & ~btn_q;
      fall_d  = ~btn_d & btn_q;
    end

    assign btn_o[n]  = btn_q;
    assign rise_o[n] = rise_q;
    assign fall_o[n] = fall_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    always_comb begin
      hold_d = hold_q;
      if (!btn_q) begin
        hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
      end
      // saturation gives at most one pulse per press
      long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    end

    assign long_o[n] = long_q;
`else
    assign long_o[n] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (WIDTH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk_100mhz;
  logic       reset;
  logic [1:0] btn_i;
  logic [1:0] btn_o, rise_o, fall_o, long_o;

  int n_cmp = 0;
  int n_err = 0;

  btn_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20),
    .LONG_CYCLES    (16)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .reset     (reset),
    .btn_i     (btn_i),
    .btn_o     (btn_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .long_o    (long_o)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
  endtask

  initial begin
    logic [1:0] e;
    reset = 1'b1;
    btn_i = 2'b00;
    tick();
    tick();
    check("reset btn_o", btn_o, 2'b00);
    check("reset rise_o", rise_o, 2'b00);
    check("reset fall_o", fall_o, 2'b00);
    check("reset long_o", long_o, 2'b00);
    reset = 1'b0;
    tick();
    tick();

    // clean press on channel 0, held long enough for a long-press pulse
    btn_i = 2'b01;
    for (int k = 1; k <= 46; k++) begin
      tick();
      check($sformatf("press btn_o k=%0d", k), btn_o, (k >= 6) ? 2'b01 : 2'b00);
      check($sformatf("press rise_o k=%0d", k), rise_o, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("press fall_o k=%0d", k), fall_o, 2'b00);
      e = (LP && k == 22) ? 2'b01 : 2'b00;
      check($sformatf("press long_o k=%0d", k), long_o, e);
    end

    // release channel 0
    btn_i = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("release btn_o k=%0d", k), btn_o, (k < 6) ? 2'b01 : 2'b00);
      check($sformatf("release fall_o k=%0d", k), fall_o, (k == 6) ? 2'b01 : 2'b00);
      check($sformatf("release rise_o k=%0d", k), rise_o, 2'b00);
      check($sformatf("release long_o k=%0d", k), long_o, 2'b00);
    end

    // bounce 1,0,1,0 every 2 cycles, final 0->1 edge at k=8
    for (int k = 0; k < 18; k++) begin
      if (k < 2)      btn_i = 2'b01;
      else if (k < 4) btn_i = 2'b00;
      else if (k < 6) btn_i = 2'b01;
      else if (k < 8) btn_i = 2'b00;
      else            btn_i = 2'b01;
      tick();
      check($sformatf("bounce btn_o k=%0d", k + 1), btn_o, (k + 1 >= 14) ? 2'b01 : 2'b00);
      check($sformatf("bounce rise_o k=%0d", k + 1), rise_o, (k + 1 == 14) ? 2'b01 : 2'b00);
      check($sformatf("bounce fall_o k=%0d", k + 1), fall_o, 2'b00);
    end

    // reset while channel 1 is pending
    btn_i = 2'b11;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midreset btn_o", btn_o, 2'b00);
    check("midreset rise_o", rise_o, 2'b00);
    check("midreset fall_o", fall_o, 2'b00);
    check("midreset long_o", long_o, 2'b00);
    @(negedge clk_100mhz);
    tick();
    check("midreset held btn_o", btn_o, 2'b00);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("postreset btn_o k=%0d", k), btn_o, (k >= 6) ? 2'b11 : 2'b00);
      check($sformatf("postreset rise_o k=%0d", k), rise_o, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("postreset fall_o k=%0d", k), fall_o, 2'b00);
    end

    // simultaneous release then simultaneous press
    btn_i = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("simrel btn_o k=%0d", k), btn_o, (k < 6) ? 2'b11 : 2'b00);
      check($sformatf("simrel fall_o k=%0d", k), fall_o, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("simrel rise_o k=%0d", k), rise_o, 2'b00);
    end
    btn_i = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("simpress btn_o k=%0d", k), btn_o, (k >= 6) ? 2'b11 : 2'b00);
      check($sformatf("simpress rise_o k=%0d", k), rise_o, (k == 6) ? 2'b11 : 2'b00);
      check($sformatf("simpress fall_o k=%0d", k), fall_o, 2'b00);
      check($sformatf("simpress long_o k=%0d", k), long_o, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
